// File: rtl/spi_write_tx.sv
// SPI mode-0 (CPOL=0, CPHA=0) master transmitter.
// Loads one Width-bit word in parallel and shifts it out MSB first on mosi_o,
// framed by cs_n_o and clocked by sclk_o. Every output is registered, so
// there is no combinational path from any input to any output.
module spi_write_tx #(
    parameter int Width  = 16,
    parameter int ClkDiv = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] din_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             mosi_o,
    output logic             cs_n_o
);

    localparam int BIT_W = $clog2(Width);
    localparam int DIV_W = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Width - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ClkDiv - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL
    } state_t;

    state_t             state_q, state_d;

    // The MSB of the loaded word lives in the mosi_o register itself, so the
    // shift register only keeps the bits that are still waiting to go out.
    logic [Width-2:0]   rest_q,  rest_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [DIV_W-1:0]   div_q,   div_d;

    logic               sclk_d;
    logic               mosi_d;
    logic               cs_n_d;
    logic               busy_d;
    logic               done_d;

    logic               phase_end;

    // A phase (LEAD, HIGH, LOW or TRAIL) lasts exactly ClkDiv cycles.
    assign phase_end = (div_q == DIV_LAST);

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through this block leaves a value unassigned (no latches).
        state_d = state_q;
        rest_d  = rest_q;
        bit_d   = bit_q;
        div_d   = phase_end ? '0 : div_q + 1'b1;
        sclk_d  = sclk_o;
        mosi_d  = mosi_o;
        cs_n_d  = cs_n_o;
        busy_d  = busy_o;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                div_d  = '0;
                sclk_d = 1'b0;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (start_i) begin
                    rest_d  = din_i[Width-2:0];
                    mosi_d  = din_i[Width-1];
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LEAD;
                end
            end

            // CS setup time before the first rising SCLK edge.
            S_LEAD: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end

            // Slave samples on the rising edge; data moves on the falling one.
            S_HIGH: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_TRAIL;
                    end else begin
                        mosi_d  = rest_q[Width-2];
                        rest_d  = rest_q << 1;
                        bit_d   = bit_q + 1'b1;
                        state_d = S_LOW;
                    end
                end
            end

            S_LOW: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end

            // CS hold time after the last falling SCLK edge.
            S_TRAIL: begin
                sclk_d = 1'b0;
                if (phase_end) begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                div_d   = '0;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            rest_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sclk_o  <= 1'b0;
            mosi_o  <= 1'b0;
            cs_n_o  <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates
            // from the values present before the edge, independent of order.
            state_q <= state_d;
            rest_q  <= rest_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sclk_o  <= sclk_d;
            mosi_o  <= mosi_d;
            cs_n_o  <= cs_n_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_write_tx.sv
// Self-checking bench for spi_write_tx: a 16-bit/ClkDiv=4 instance and a
// 2-bit/ClkDiv=1 corner instance, each observed by a slave-side monitor that
// rebuilds the word from mosi_o on sclk_o rising edges and measures framing.
module tb_spi_write_tx;

    logic        clk = 1'b0;

    logic        rst_a_n, start_a;
    logic [15:0] din_a;
    logic        busy_a, done_a, sclk_a, mosi_a, csn_a;

    logic        rst_b_n, start_b;
    logic [1:0]  din_b;
    logic        busy_b, done_b, sclk_b, mosi_b, csn_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    spi_write_tx #(.Width(16), .ClkDiv(4)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst_a_n),
        .start_i (start_a),
        .din_i   (din_a),
        .busy_o  (busy_a),
        .done_o  (done_a),
        .sclk_o  (sclk_a),
        .mosi_o  (mosi_a),
        .cs_n_o  (csn_a)
    );

    spi_write_tx #(.Width(2), .ClkDiv(1)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst_b_n),
        .start_i (start_b),
        .din_i   (din_b),
        .busy_o  (busy_b),
        .done_o  (done_b),
        .sclk_o  (sclk_b),
        .mosi_o  (mosi_b),
        .cs_n_o  (csn_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive the request inputs of one instance (sel=0: A, sel=1: B).
    task automatic set_in(input bit sel, input logic start, input logic [31:0] din);
        if (sel) begin
            start_b = start;
            din_b   = din[1:0];
        end else begin
            start_a = start;
            din_a   = din[15:0];
        end
    endtask

    // Outputs packed as {cs_n, sclk, mosi, busy, done}.
    function automatic logic [4:0] outs(input bit sel);
        return sel ? {csn_b, sclk_b, mosi_b, busy_b, done_b}
                   : {csn_a, sclk_a, mosi_a, busy_a, done_a};
    endfunction

    // Request a frame at a negedge; returns one negedge later with start low.
    task automatic kick(input bit sel, input logic [31:0] word);
        set_in(sel, 1'b1, word);
        @(negedge clk);
        set_in(sel, 1'b0, $urandom);
    endtask

    // Observe one frame from the cycle after acceptance until done_o.
    // noise_at: cycle at which a stray start with all-ones data is pulsed (-1: none).
    // chain:    request next_word in the done_o cycle.
    task automatic watch(input bit sel, input int width, input int clkdiv,
                         input logic [31:0] word, input int noise_at,
                         input bit chain, input logic [31:0] next_word);
        int          busy_cyc = 0, rises = 0, toggles = 0, hold_err = 0, cs_err = 0;
        bit          seen = 0;
        logic        prev_sclk = 1'b0, hold = 1'b0;
        logic [31:0] cap = '0;
        logic [31:0] mask;
        logic [4:0]  o;
        mask = (32'd1 << width) - 32'd1;
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            o = outs(sel);
            if (o[1]) busy_cyc++;
            if (o[3] != prev_sclk) toggles++;
            if (o[3] && !prev_sclk) begin
                rises++;
                cap  = (cap << 1) | {31'd0, o[2]};
                hold = o[2];
            end else if (o[3] && o[2] != hold) begin
                hold_err++;
            end
            if (o[4] != !o[1]) cs_err++;
            prev_sclk = o[3];
            if (o[0]) begin
                seen = 1;
                if (chain) begin
                    check("cs_gap_high", {31'd0, o[4]}, 32'd1);
                    set_in(sel, 1'b1, next_word);
                end
            end else if (cyc == noise_at) begin
                set_in(sel, 1'b1, 32'hFFFF_FFFF);
            end else begin
                set_in(sel, 1'b0, $urandom);
            end
            if (!seen) @(negedge clk);
        end
        check("done_seen",  {31'd0, seen}, 32'd1);
        check("busy_len",   busy_cyc, (2 * width + 1) * clkdiv);
        check("rise_count", rises, width);
        check("toggles",    toggles, 2 * width);
        check("slave_word", cap & mask, word & mask);
        check("mosi_hold",  hold_err, 0);
        check("cs_vs_busy", cs_err, 0);
        @(negedge clk);
        o = outs(sel);
        if (chain) begin
            set_in(sel, 1'b0, $urandom);
            check("b2b_started", {30'd0, o[4], o[1]}, 32'b01);
        end else begin
            check("done_width", {31'd0, o[0]}, 32'd0);
        end
    endtask

    initial begin
        int          rises;
        int          bad_cyc;
        logic [31:0] w, w2;
        logic        prev;

        // T1: reset held with start asserted.
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        set_in(0, 1'b1, 32'hA5C3);
        set_in(1, 1'b1, 32'h3);
        repeat (4) @(negedge clk);
        check("rst_outs_a", outs(0), 5'b10000);
        check("rst_outs_b", outs(1), 5'b10000);
        set_in(0, 1'b0, 32'h0);
        set_in(1, 1'b0, 32'h0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst_a", outs(0), 5'b10000);
        check("idle_after_rst_b", outs(1), 5'b10000);

        // T2: single frame.
        kick(0, 32'hA5C3);
        watch(0, 16, 4, 32'hA5C3, -1, 0, 0);

        // T3: stray start mid-frame is ignored.
        kick(0, 32'hA5C3);
        watch(0, 16, 4, 32'hA5C3, 40, 0, 0);
        repeat (3) @(negedge clk);
        check("no_queued_frame", {31'd0, busy_a}, 32'd0);

        // T4: back-to-back frames, second requested in the done_o cycle.
        kick(0, 32'hA5C3);
        watch(0, 16, 4, 32'hA5C3, -1, 1, 32'h1234);
        watch(0, 16, 4, 32'h1234, -1, 0, 0);

        // T5: reset after five rising SCLK edges.
        kick(0, 32'hBEEF);
        rises = 0;
        prev  = 1'b0;
        for (int cyc = 0; cyc < 500 && rises < 5; cyc++) begin
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            if (rises < 5) @(negedge clk);
        end
        check("rises_before_abort", rises, 5);
        rst_a_n = 1'b0;
        #1;
        check("abort_outs", {csn_a, sclk_a, busy_a, done_a}, 4'b1000);
        bad_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_a || busy_a) bad_cyc++;
        end
        rst_a_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_a || busy_a) bad_cyc++;
        end
        check("abort_no_done", bad_cyc, 0);
        kick(0, 32'h8001);
        watch(0, 16, 4, 32'h8001, -1, 0, 0);

        // T6: smallest legal configuration.
        kick(1, 32'b10);
        watch(1, 2, 1, 32'b10, -1, 0, 0);

        // Randomized frames on both instances.
        for (int n = 0; n < 8; n++) begin
            w  = $urandom & 32'hFFFF;
            w2 = $urandom & 32'hFFFF;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            kick(0, w);
            if ($urandom_range(0, 3) == 0) begin
                watch(0, 16, 4, w, $urandom_range(2, 120), 1, w2);
                watch(0, 16, 4, w2, -1, 0, 0);
            end else begin
                watch(0, 16, 4, w, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 120) : -1, 0, 0);
            end
        end
        for (int n = 0; n < 6; n++) begin
            w  = $urandom & 32'h3;
            w2 = $urandom & 32'h3;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            kick(1, w);
            watch(1, 2, 1, w, $urandom_range(0, 3), n[0], w2);
            if (n[0]) watch(1, 2, 1, w2, -1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
